// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker; sel 0 = a, 1 = b.
module rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic grant_valid,
    output logic grant_sel
);

    assign grant_valid = req_a | req_b;
    // On a tie the side that did not win last time gets the slot
    assign grant_sel = (req_a & req_b) ? ~last : req_b;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin CPU/DMA arbiter for a single-port sync-read memory.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic              owner_q;
    logic              last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cpu_elig;
    logic              dma_elig;
    logic              other_elig;
    logic              gnt_valid;
    logic              gnt_sel;
    logic              load;
    logic              load_sel;

    // A requester still holding req during its ack cycle is not re-granted
    assign cpu_elig = cpu_req & ~cpu_ack;
    assign dma_elig = dma_req & ~dma_ack;
    assign other_elig = (owner_q == OWN_CPU) ? dma_elig : cpu_elig;

    rr_pick2 u_pick (
        .req_a       (cpu_elig),
        .req_b       (dma_elig),
        .last        (last_q),
        .grant_valid (gnt_valid),
        .grant_sel   (gnt_sel)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_sel  = gnt_sel;
        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    load      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: state_nxt = CAPTURE;
            CAPTURE: begin
                if (other_elig) begin
                    load      = 1'b1;
                    load_sel  = ~owner_q;
                    state_nxt = ACCESS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner_q <= OWN_CPU;
            last_q  <= OWN_DMA;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
        end else begin
            state   <= state_nxt;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            if (state == CAPTURE) begin
                if (!we_q) rdata <= mem_rdata;
                cpu_ack <= (owner_q == OWN_CPU);
                dma_ack <= (owner_q == OWN_DMA);
            end
            if (load) begin
                owner_q <= load_sel;
                last_q  <= load_sel;
                we_q    <= load_sel ? dma_we : cpu_we;
                addr_q  <= load_sel ? dma_addr : cpu_addr;
                wdata_q <= load_sel ? dma_wdata : cpu_wdata;
            end
        end
    end

    assign mem_en    = (state == ACCESS);
    assign mem_we    = we_q & mem_en;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a sync-read memory model.
module tb_mem_port_arbiter;

    typedef struct {
        logic       own;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [4:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_ack;
    logic       dma_req = 1'b0;
    logic       dma_we = 1'b0;
    logic [4:0] dma_addr = '0;
    logic [7:0] dma_wdata = '0;
    logic       dma_ack;
    logic [7:0] rdata;
    logic       mem_en;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic       busy;

    logic [7:0] mem [32];
    logic [7:0] ref_mem [32];
    logic       tb_wr = 1'b0;
    logic [4:0] tb_wa = '0;
    logic [7:0] tb_wd = '0;
    logic [7:0] last_rd = '0;
    exp_t       sbq [$];
    logic       prev_c = 1'b0;
    logic       prev_d = 1'b0;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_ack   (dma_ack),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_wr) begin
            mem[tb_wa] <= tb_wd;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    // Every ack pops one expected access: owner, rdata, exclusivity
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_c = 1'b0;
            prev_d = 1'b0;
        end else if (cpu_ack || dma_ack) begin
            tests++;
            if (cpu_ack && dma_ack) begin
                fails++;
                $display("FAIL ack_overlap: cpu_ack=1 dma_ack=1, want only one");
            end else if ((cpu_ack && prev_c) || (dma_ack && prev_d)) begin
                fails++;
                $display("FAIL ack_repeat: ack high two cycles, want single pulse");
            end else if (sbq.size() == 0) begin
                fails++;
                $display("FAIL ack_unexpected: cpu=%0b dma=%0b, want no ack", cpu_ack, dma_ack);
            end else begin
                e = sbq.pop_front();
                if (dma_ack !== e.own || rdata !== e.data) begin
                    fails++;
                    $display("FAIL ack_check: own=%0d rdata=%h, want own=%0d rdata=%h",
                             dma_ack, rdata, e.own, e.data);
                end
            end
        end
        if (!rst) begin
            prev_c = cpu_ack;
            prev_d = dma_ack;
        end
    end

    task automatic push_exp(input logic own, input logic we,
                            input logic [4:0] a, input logic [7:0] d);
        exp_t e;
        e.own = own;
        if (we) begin
            ref_mem[a] = d;
            e.data = last_rd;
        end else begin
            e.data = ref_mem[a];
            last_rd = e.data;
        end
        sbq.push_back(e);
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        tb_wr = 1'b1;
        tb_wa = a;
        tb_wd = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 tb_wr = 1'b0;
    endtask

    task automatic do_reset();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        rst = 1'b1;
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        rst = 1'b1;
        last_rd = '0;
        #1;
        tests++;
        if ({busy, mem_en, mem_we, cpu_ack, dma_ack, rdata, mem_addr, mem_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%0b en=%0b we=%0b ack=%0b%0b rdata=%h, want all 0",
                     busy, mem_en, mem_we, cpu_ack, dma_ack, rdata);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, mem_en, cpu_ack, dma_ack} !== 4'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%0b en=%0b, want 0 with no requests", busy, mem_en);
        end
    endtask

    task automatic test_cpu_read();
        logic [7:0] en_bits = '0;
        int         cack = -1;
        logic       dseen = 1'b0;
        logic [7:0] rd = '0;
        logic [4:0] a1 = '0;
        preload(5'd5, 8'hA7);
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
        push_exp(1'b0, 1'b0, 5'd5, 8'h00);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            en_bits[k] = mem_en;
            if (k == 1) a1 = mem_addr;
            if (dma_ack) dseen = 1'b1;
            if (cpu_ack && cack < 0) begin
                cack = k;
                rd = rdata;
                cpu_req = 1'b0;
            end
        end
        tests++;
        if (en_bits !== 8'b0000_0010) begin
            fails++;
            $display("FAIL read_mem_en: cycles=%b, want 00000010", en_bits);
        end
        tests++;
        if (cack !== 3 || rd !== 8'hA7) begin
            fails++;
            $display("FAIL read_ack: cycle=%0d rdata=%h, want cycle 3 rdata a7", cack, rd);
        end
        tests++;
        if (dseen !== 1'b0 || a1 !== 5'd5) begin
            fails++;
            $display("FAIL read_side: dma_ack=%0b addr=%0d, want 0 and 5", dseen, a1);
        end
    endtask

    task automatic test_simultaneous();
        logic [9:0] en_bits = '0;
        int         cack = -1;
        int         dack = -1;
        logic [7:0] drd = '0;
        logic       we1 = 1'b0;
        do_reset();
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd3; cpu_wdata = 8'h11;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 5'd3;
        push_exp(1'b0, 1'b1, 5'd3, 8'h11);
        push_exp(1'b1, 1'b0, 5'd3, 8'h00);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            en_bits[k] = mem_en;
            if (k == 1) we1 = mem_we;
            if (cpu_ack && cack < 0) begin
                cack = k;
                cpu_req = 1'b0;
            end
            if (dma_ack && dack < 0) begin
                dack = k;
                drd = rdata;
                dma_req = 1'b0;
            end
        end
        tests++;
        if (en_bits !== 10'b00_0000_1010 || we1 !== 1'b1) begin
            fails++;
            $display("FAIL simul_mem_en: cycles=%b we1=%0b, want 0000001010 and 1", en_bits, we1);
        end
        tests++;
        if (cack !== 3 || dack !== 5 || drd !== 8'h11) begin
            fails++;
            $display("FAIL simul_order: cpu_ack=%0d dma_ack=%0d rdata=%h, want 3 5 11",
                     cack, dack, drd);
        end
    endtask

    task automatic test_fairness();
        int         ci = 0;
        int         di = 0;
        int         nacks = 0;
        int         last_ack = -1;
        logic [7:0] seq = '0;
        logic       overlap = 1'b0;
        for (int n = 0; n < 4; n++) begin
            push_exp(1'b0, 1'b1, 5'(8 + n), 8'(8'h40 + n));
            push_exp(1'b1, 1'b0, 5'(8 + n), 8'h00);
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd8; cpu_wdata = 8'h40;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 5'd8;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (cpu_ack && dma_ack) overlap = 1'b1;
            if (cpu_ack || dma_ack) begin
                if (nacks < 8) seq[nacks] = dma_ack;
                nacks++;
                last_ack = k;
            end
            if (cpu_ack) begin
                ci++;
                if (ci < 4) begin
                    cpu_addr = 5'(8 + ci);
                    cpu_wdata = 8'(8'h40 + ci);
                end else begin
                    cpu_req = 1'b0;
                end
            end
            if (dma_ack) begin
                di++;
                if (di < 4) dma_addr = 5'(8 + di);
                else dma_req = 1'b0;
            end
        end
        tests++;
        if (nacks !== 8 || seq !== 8'hAA) begin
            fails++;
            $display("FAIL fair_order: acks=%0d seq=%b, want 8 and 10101010", nacks, seq);
        end
        tests++;
        if (overlap !== 1'b0 || last_ack !== 17) begin
            fails++;
            $display("FAIL fair_rate: overlap=%0b last_ack=%0d, want 0 and 17", overlap, last_ack);
        end
    endtask

    task automatic test_rdata_hold();
        int         dack = -1;
        logic [7:0] drd = '0;
        logic [7:0] rd4 = '0;
        preload(5'd12, 8'h3C);
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd12;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 5'd13; dma_wdata = 8'hFF;
        push_exp(1'b0, 1'b0, 5'd12, 8'h00);
        push_exp(1'b1, 1'b1, 5'd13, 8'hFF);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 4) rd4 = rdata;
            if (cpu_ack) cpu_req = 1'b0;
            if (dma_ack && dack < 0) begin
                dack = k;
                drd = rdata;
                dma_req = 1'b0;
            end
        end
        tests++;
        if (dack !== 5 || drd !== 8'h3C || rd4 !== 8'h3C) begin
            fails++;
            $display("FAIL hold_rdata: dma_ack=%0d rdata=%h mid=%h, want 5 3c 3c", dack, drd, rd4);
        end
        tests++;
        if (mem[13] !== 8'hFF) begin
            fails++;
            $display("FAIL hold_write: mem[13]=%h, want ff", mem[13]);
        end
    endtask

    task automatic test_reset_access();
        logic       en1;
        logic       dseen = 1'b0;
        int         cack = -1;
        logic [7:0] rd = '0;
        preload(5'd20, 8'h66);
        @(posedge clk);
        #1;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 5'd20; dma_wdata = 8'h5A;
        @(posedge clk);
        #1 en1 = mem_en;
        rst = 1'b1;
        dma_req = 1'b0;
        last_rd = '0;
        #1;
        tests++;
        if (en1 !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_access: en_before=%0b en=%0b we=%0b busy=%0b, want 1 0 0 0",
                     en1, mem_en, mem_we, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (dma_ack) dseen = 1'b1;
        end
        tests++;
        if (dseen !== 1'b0 || mem[20] !== 8'h66) begin
            fails++;
            $display("FAIL rst_abort: dma_ack=%0b mem[20]=%h, want 0 and 66", dseen, mem[20]);
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd20;
        push_exp(1'b0, 1'b0, 5'd20, 8'h00);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cpu_ack && cack < 0) begin
                cack = k;
                rd = rdata;
                cpu_req = 1'b0;
            end
        end
        tests++;
        if (cack !== 3 || rd !== 8'h66) begin
            fails++;
            $display("FAIL rst_recover: cpu_ack=%0d rdata=%h, want 3 and 66", cack, rd);
        end
    endtask

    task automatic test_held_req();
        int   nacks = 0;
        int   first = -1;
        int   prev = -1;
        int   mingap = 100;
        logic consec = 1'b0;
        logic pc = 1'b0;
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
        for (int n = 0; n < 3; n++) push_exp(1'b0, 1'b0, 5'd5, 8'h00);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (cpu_ack && pc) consec = 1'b1;
            pc = cpu_ack;
            if (cpu_ack) begin
                nacks++;
                if (first < 0) first = k;
                if (prev >= 0 && k - prev < mingap) mingap = k - prev;
                prev = k;
            end
            if (k == 9) cpu_req = 1'b0;
        end
        tests++;
        if (nacks !== 3 || first !== 3) begin
            fails++;
            $display("FAIL held_count: acks=%0d first=%0d, want 3 and 3", nacks, first);
        end
        tests++;
        if (consec !== 1'b0 || mingap < 3) begin
            fails++;
            $display("FAIL held_spacing: consecutive=%0b min_gap=%0d, want 0 and >=3",
                     consec, mingap);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        test_reset();
        test_cpu_read();
        test_simultaneous();
        test_fairness();
        test_rdata_hold();
        test_reset_access();
        test_held_req();
        repeat (3) @(posedge clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d pending, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
